// File: rtl/svm_window_classifier_pkg.sv
// HOG window layout definitions shared by the window assembler and the SVM classifier,
// so both ends agree on block and feature bit positions.
package svm_window_classifier_pkg;

  localparam int BLOCK_PIXELS      = 16;
  localparam int WINDOW_BLOCK_COLS = 4;
  localparam int WINDOW_BLOCK_ROWS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESULT
  } state_t;

  function automatic int features(input int input_width, input int feature_width);
    return input_width / feature_width;
  endfunction

  // Block b = row*4+col sits at b*input_width, block 0 at the LSBs of the window bus.
  function automatic int block_lsb(input int blk, input int input_width);
    return blk * input_width;
  endfunction

  function automatic int feature_lsb(input int f, input int feature_width);
    return f * feature_width;
  endfunction

endpackage

// File: rtl/svm_weight_mem.sv
// Per-block SVM weight register file: one synchronous write port, one combinational read port.
module svm_weight_mem #(
  parameter int DEPTH  = 32,
  parameter int WORD_W = 72,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/svm_window_classifier.sv
// Linear SVM scorer: accepts one 32-block window, accumulates one block per cycle,
// then presents score, detect flag and window grid position until taken downstream.
module svm_window_classifier
  import svm_window_classifier_pkg::*;
#(
  parameter int IMAGE_WIDTH       = 640,
  parameter int IMAGE_HEIGHT      = 480,
  parameter int INPUT_WIDTH       = 36,
  parameter int BLOCKS_PER_WINDOW = 32,
  parameter int FEATURE_WIDTH     = 4,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACC_WIDTH         = 24,
  parameter int WINDOW_WIDTH      = INPUT_WIDTH * BLOCKS_PER_WINDOW,
  localparam int FEATURES         = features(INPUT_WIDTH, FEATURE_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WINDOW_WIDTH-1:0]           detection_window,
  input  logic                              w_wr_en,
  input  logic [4:0]                        w_wr_addr,
  input  logic [FEATURES*WEIGHT_WIDTH-1:0]  w_wr_data,
  input  logic signed [ACC_WIDTH-1:0]       threshold,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [ACC_WIDTH-1:0]       score,
  output logic                              detect,
  output logic [5:0]                        win_x,
  output logic [4:0]                        win_y
);

  localparam int WIN_COLS = IMAGE_WIDTH / BLOCK_PIXELS - (WINDOW_BLOCK_COLS - 1);
  localparam int WIN_ROWS = IMAGE_HEIGHT / BLOCK_PIXELS - (WINDOW_BLOCK_ROWS - 1);
  localparam int PROD_W   = FEATURE_WIDTH + WEIGHT_WIDTH + 1;
  localparam logic [4:0] LAST_BLK = 5'(BLOCKS_PER_WINDOW - 1);
  localparam logic [5:0] LAST_X   = 6'(WIN_COLS - 1);
  localparam logic [4:0] LAST_Y   = 5'(WIN_ROWS - 1);

  // Dot product of one block: unsigned features times signed weights, sign-extended.
  function automatic logic signed [ACC_WIDTH-1:0] block_dot(
    input logic [INPUT_WIDTH-1:0]            feats,
    input logic [FEATURES*WEIGHT_WIDTH-1:0]  wts
  );
    logic signed [ACC_WIDTH-1:0]     sum;
    logic signed [FEATURE_WIDTH:0]   feat;
    logic signed [WEIGHT_WIDTH-1:0]  wt;
    logic signed [PROD_W-1:0]        prod;
    sum = '0;
    for (int f = 0; f < FEATURES; f++) begin
      feat = $signed({1'b0, feats[feature_lsb(f, FEATURE_WIDTH) +: FEATURE_WIDTH]});
      wt   = $signed(wts[f*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      prod = feat * wt;
      sum  = sum + ACC_WIDTH'(prod);
    end
    return sum;
  endfunction

  state_t                            state;
  logic [4:0]                        blk;
  logic [5:0]                        pos_x;
  logic [4:0]                        pos_y;
  logic signed [ACC_WIDTH-1:0]       acc;
  logic signed [ACC_WIDTH-1:0]       acc_next;
  logic [WINDOW_WIDTH-1:0]           win_hold;
  logic [INPUT_WIDTH-1:0]            cur_block;
  logic [FEATURES*WEIGHT_WIDTH-1:0]  w_rd;

  svm_weight_mem #(
    .DEPTH  (BLOCKS_PER_WINDOW),
    .WORD_W (FEATURES*WEIGHT_WIDTH),
    .ADDR_W (5)
  ) u_weight_mem (
    .clk     (clk),
    .wr_en   (w_wr_en && (state == IDLE)),
    .wr_addr (w_wr_addr),
    .wr_data (w_wr_data),
    .rd_addr (blk),
    .rd_data (w_rd)
  );

  assign cur_block = win_hold[block_lsb(int'(blk), INPUT_WIDTH) +: INPUT_WIDTH];
  assign acc_next  = acc + block_dot(cur_block, w_rd);

  always_ff @(posedge clk) begin
    if ((state == IDLE) && in_valid) win_hold <= detection_window;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      score     <= '0;
      detect    <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
      acc       <= '0;
      blk       <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= ACCUM;
            in_ready <= 1'b0;
            acc      <= '0;
            blk      <= '0;
            win_x    <= pos_x;
            win_y    <= pos_y;
            if (pos_x == LAST_X) begin
              pos_x <= '0;
              pos_y <= (pos_y == LAST_Y) ? '0 : pos_y + 5'd1;
            end else begin
              pos_x <= pos_x + 6'd1;
            end
          end
        end
        ACCUM: begin
          acc <= acc_next;
          blk <= blk + 5'd1;
          if (blk == LAST_BLK) begin
            state     <= RESULT;
            out_valid <= 1'b1;
            score     <= acc_next;
            detect    <= (acc_next > threshold);
          end
        end
        RESULT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_window_classifier.sv
// Directed bench for svm_window_classifier with hand-computed scores and positions.
module tb_svm_window_classifier;

  localparam int NB   = 32;
  localparam int NF   = 9;
  localparam int WW   = 8;
  localparam int AW   = 24;
  localparam int WINW = 1152;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WINW-1:0]      detection_window = '0;
  logic                 w_wr_en = 1'b0;
  logic [4:0]           w_wr_addr = '0;
  logic [NF*WW-1:0]     w_wr_data = '0;
  logic signed [AW-1:0] threshold = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [AW-1:0] score;
  logic                 detect;
  logic [5:0]           win_x;
  logic [4:0]           win_y;

  int checks = 0;
  int errors = 0;
  int lat;

  svm_window_classifier dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .detection_window (detection_window),
    .w_wr_en          (w_wr_en),
    .w_wr_addr        (w_wr_addr),
    .w_wr_data        (w_wr_data),
    .threshold        (threshold),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .score            (score),
    .detect           (detect),
    .win_x            (win_x),
    .win_y            (win_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // sel < 0 fills every block, otherwise only block sel gets value v.
  function automatic logic [WINW-1:0] fill_win(input int sel, input logic [3:0] v);
    logic [WINW-1:0] w;
    w = '0;
    for (int b = 0; b < NB; b++)
      for (int f = 0; f < NF; f++)
        if (sel < 0 || sel == b) w[b*36 + f*4 +: 4] = v;
    return w;
  endfunction

  function automatic logic [NF*WW-1:0] wconst(input logic [7:0] v);
    logic [NF*WW-1:0] d;
    for (int f = 0; f < NF; f++) d[f*WW +: WW] = v;
    return d;
  endfunction

  function automatic logic [NF*WW-1:0] wseq();
    logic [NF*WW-1:0] d;
    for (int f = 0; f < NF; f++) d[f*WW +: WW] = 8'(f + 1);
    return d;
  endfunction

  task automatic wr_weight(input int a, input logic [NF*WW-1:0] d);
    w_wr_en   = 1'b1;
    w_wr_addr = a[4:0];
    w_wr_data = d;
    @(negedge clk);
    w_wr_en   = 1'b0;
  endtask

  task automatic wr_all(input logic [NF*WW-1:0] d);
    for (int a = 0; a < NB; a++) wr_weight(a, d);
  endtask

  // Handshake one window; optionally a weight write shares the accepting cycle.
  task automatic send_window(input logic [WINW-1:0] w, input bit do_wr, input int a,
                             input logic [NF*WW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    detection_window = w;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("handshake_timeout", 0, 1);
    if (do_wr) begin
      w_wr_en   = 1'b1;
      w_wr_addr = a[4:0];
      w_wr_data = d;
    end
    @(negedge clk);
    in_valid = 1'b0;
    w_wr_en  = 1'b0;
  endtask

  // Starts on the negedge right after the handshake edge; latency counts the handshake cycle.
  task automatic wait_result(output int latency);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("result_timeout", 0, 1);
    latency = n + 1;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int exp_score, input bit exp_det,
                               input int ex, input int ey);
    check({tag, "_score"}, score, exp_score);
    check({tag, "_detect"}, detect, exp_det);
    check({tag, "_x"}, win_x, ex);
    check({tag, "_y"}, win_y, ey);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_score", score, 0);
    check("rst_detect", detect, 0);
    check("rst_x", win_x, 0);
    check("rst_y", win_y, 0);

    wr_all(wconst(8'd1));
    threshold = 24'sd287;
    send_window(fill_win(-1, 4'd1), 1'b0, 0, '0);
    wait_result(lat);
    check("ones_latency", lat, 33);
    expect_result("ones", 288, 1'b1, 0, 0);
    take_result();
    check("ones_taken_valid", out_valid, 0);
    check("ones_taken_ready", in_ready, 1);

    wr_all(wconst(8'h80));
    threshold = 24'sd0;
    send_window(fill_win(-1, 4'd15), 1'b0, 0, '0);
    wait_result(lat);
    expect_result("minneg", -552960, 1'b0, 1, 0);
    take_result();

    wr_all(wconst(8'd0));
    wr_weight(5, wseq());
    threshold = 24'sd89;
    send_window(fill_win(5, 4'd2), 1'b0, 0, '0);
    wait_result(lat);
    expect_result("blk5_t89", 90, 1'b1, 2, 0);
    take_result();
    threshold = 24'sd90;
    send_window(fill_win(5, 4'd2), 1'b0, 0, '0);
    wait_result(lat);
    expect_result("blk5_t90", 90, 1'b0, 3, 0);
    take_result();

    threshold = 24'sd0;
    send_window(fill_win(5, 4'd2), 1'b1, 5, wconst(8'd3));
    wait_result(lat);
    expect_result("wr_same_cycle", 54, 1'b1, 4, 0);
    take_result();

    wr_all(wconst(8'd1));
    threshold = 24'sd287;
    send_window(fill_win(-1, 4'd1), 1'b0, 0, '0);
    wait_result(lat);
    in_valid = 1'b1;
    detection_window = fill_win(-1, 4'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_score", score, 288);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    check("stall_x", win_x, 5);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_release_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    check("second_latency", lat, 33);
    expect_result("second", 576, 1'b1, 6, 0);
    take_result();

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 37*23 + 1; i++) begin
      send_window('0, 1'b0, 0, '0);
      wait_result(lat);
      check($sformatf("pos_%0d", i), {win_x, win_y}, {6'((i % 37)), 5'(((i / 37) % 23))});
      take_result();
    end
    check("pos_last_x", win_x, 0);
    check("pos_last_y", win_y, 0);

    send_window(fill_win(-1, 4'd1), 1'b0, 0, '0);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_score", score, 0);
    check("midrst_x", win_x, 0);
    send_window(fill_win(-1, 4'd1), 1'b0, 0, '0);
    repeat (3) @(negedge clk);
    wr_weight(0, wconst(8'd5));
    wait_result(lat);
    expect_result("after_rst", 288, 1'b1, 0, 0);
    take_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
